alu_exec_unit: RTL
==================

# alu_exec_unit

Multi-cycle execution unit for the datapath: consumes the 4-bit ALU select code produced by the ALU control decoder and executes it on two operands. Single-cycle ops (AND, OR, ADD, SUB, SLT) complete in one cycle. MULT and DIV run as iterative 32-step shift-add and restoring-divide engines. A start/busy/done handshake lets the control unit stall while a long operation is in flight.

## Interface
Parameters:
- WIDTH, 32, operand and result width; iteration count equals WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- Start  input  1  request; accepted only when Busy=0.
- ALUS  input  4  operation select, sampled on accept.
- A, B  input  WIDTH  operands, sampled on accept.
- Busy  output  1  high from the cycle after accept until Done.
- Done  output  1  one-cycle pulse when results are valid.
- Lo  output  WIDTH  main result; MULT low word; DIV quotient.
- Hi  output  WIDTH  MULT high word; DIV remainder; 0 for single-cycle ops.
- Zero  output  1  Lo == 0, updated with Done.
- DivZero  output  1  DIV with B == 0, updated with Done.
- OpErr  output  1  ALUS not a defined code (including X/Z), updated with Done.

## Operation
- Codes: AND 0000, OR 0001, ADD 0010, MULT 0101, SUB 0110, SLT 0111, DIV 1000.
- AND/OR are bitwise. ADD/SUB wrap modulo 2^WIDTH and never trap. SLT gives Lo = 1 if signed A < signed B, else 0.
- MULT: signed 2WIDTH-bit product, {Hi,Lo}. Operands are converted to magnitudes, then WIDTH shift-add steps run, then the product is negated if the operand signs differ.
- DIV: signed and truncating toward zero. Remainder takes the sign of the dividend. Magnitude restoring divide runs for WIDTH steps, then the sign fix is applied.
- Divide by zero: no iteration. Lo = all ones, Hi = A, DivZero = 1.
- Division of -2^(WIDTH-1) by -1: Lo = 0x80000000, Hi = 0. This is the natural wrap; no flag is raised.
- Undefined code: Lo = Hi = 0, OpErr = 1, single-cycle completion.
- States:
  - IDLE: on Start and a single-cycle op, DIV-by-zero, or error, go to FINISH. On Start and MULT or DIV, go to ITER with the step counter at 0.
  - ITER: one step per cycle. After step WIDTH-1, go to FINISH.
  - FINISH: apply the sign fix, register outputs, pulse Done, return to IDLE.
- Lo, Hi and the flags hold their values until the next Done. They are not cleared on accept.

## Timing
- Reset, asynchronous: state = IDLE, Busy = 0, Done = 0, Lo = Hi = 0, Zero = 1, DivZero = 0, OpErr = 0, counter = 0.
- Accept at edge N.
  - Single-cycle op: Done = 1 in cycle N+1. Busy stays 0 throughout.
  - MULT/DIV: Busy = 1 during cycles N+1..N+WIDTH+1. Done = 1 in cycle N+WIDTH+1, which is 33 for WIDTH=32. Busy falls together with Done.
- Start while Busy = 1 is ignored; there is no queue. Start in the same cycle as Done is also ignored, because Busy is still 1.
- Back-to-back single-cycle ops: a new accept is allowed in any cycle where Busy = 0, including the Done cycle. This gives one result per cycle.
- Reset during ITER aborts the operation immediately. No Done is produced and all outputs take their reset values.
- A and B may change after accept; internal copies are used.

## Structure
- Shared package alu_pkg holds the ALUS code localparams (ALU_AND .. ALU_DIV) and the state encoding. The control decoder uses the same constants.
- One natural sub-module is alu_muldiv_iter: the iterative engine with a shared WIDTH-bit adder, an accumulator/remainder register and a step counter.
- The single-cycle datapath and the FSM live in the top module.

## Test plan
- ADD 0x7FFFFFFF + 1 -> Done at N+1, Lo = 0x80000000, Zero = 0. SUB 5 - 5 -> Lo = 0, Zero = 1.
- SLT A = 0xFFFFFFFF, B = 1 -> Lo = 1. Then SLT A = 1, B = 0xFFFFFFFF -> Lo = 0, issued back-to-back with Done on consecutive cycles.
- MULT A = -3, B = 7 -> Busy for 33 cycles, Done at N+33, {Hi,Lo} = 0xFFFFFFFF_FFFFFFEB. MULT 0xFFFFFFFF × 0xFFFFFFFF (-1 × -1) -> {Hi,Lo} = 0x0_00000001.
- DIV A = -7, B = 2 -> Lo = -3 (0xFFFFFFFD), Hi = -1 (0xFFFFFFFF). DIV 10 / 0 -> Done at N+1, Lo = 0xFFFFFFFF, Hi = 10, DivZero = 1.
- Start pulsed with a different op at cycles N+5 and N+33 of a MULT -> both ignored, MULT result unchanged. Reset asserted at N+10 of a DIV -> no Done, all outputs at reset values.
- ALUS = 4'b1111 -> Done at N+1, Lo = Hi = 0, OpErr = 1. The next valid op clears OpErr.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU select codes and execution-unit state encoding; the ALU control decoder uses the same constants.
package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_MULT = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_DIV  = 4'b1000;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ITER   = 2'd1,
    S_FINISH = 2'd2
  } state_t;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned shift-add multiplier / restoring divider sharing one adder; one step per cycle while step=1.
// nxt_hi/nxt_lo expose the post-step value so the caller can register the final result on the last step.
module alu_muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             div_mode,
  input  logic [WIDTH-1:0] ld_m,
  input  logic [WIDTH-1:0] ld_q,
  input  logic             step,
  output logic [WIDTH-1:0] nxt_hi,
  output logic [WIDTH-1:0] nxt_lo,
  output logic             last
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic             mode;
  logic [WIDTH-1:0] m;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] q;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   opa;
  logic [WIDTH:0]   opb;
  logic [WIDTH+1:0] sum;
  logic             ge;

  // Divide: shifted remainder minus divisor via inverted operand and carry-in; carry-out means no borrow.
  assign opa = mode ? {acc, q[WIDTH-1]} : {1'b0, acc};
  assign opb = mode ? ~{1'b0, m} : (q[0] ? {1'b0, m} : '0);
  assign sum = {1'b0, opa} + {1'b0, opb} + {{(WIDTH+1){1'b0}}, mode};
  assign ge  = sum[WIDTH+1];

  always_comb begin
    nxt_hi = '0;
    nxt_lo = '0;
    if (mode) begin
      nxt_hi = ge ? sum[WIDTH-1:0] : opa[WIDTH-1:0];
      nxt_lo = {q[WIDTH-2:0], ge};
    end else begin
      nxt_hi = sum[WIDTH:1];
      nxt_lo = {sum[0], q[WIDTH-1:1]};
    end
  end

  assign last = (cnt == CW'(WIDTH-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode <= 1'b0;
      m    <= '0;
      acc  <= '0;
      q    <= '0;
      cnt  <= '0;
    end else if (load) begin
      mode <= div_mode;
      m    <= ld_m;
      acc  <= '0;
      q    <= ld_q;
      cnt  <= '0;
    end else if (step) begin
      acc  <= nxt_hi;
      q    <= nxt_lo;
      cnt  <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit: single-cycle AND/OR/ADD/SUB/SLT plus iterative signed MULT/DIV behind Start/Busy/Done.
// Done one cycle after accept (WIDTH+1 cycles for MULT/DIV); Start is ignored while Busy, with no queueing.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Start,
  input  logic [3:0]       ALUS,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Lo,
  output logic [WIDTH-1:0] Hi,
  output logic             Zero,
  output logic             DivZero,
  output logic             OpErr
);

  state_t state;

  logic [WIDTH-1:0] sc_lo;
  logic [WIDTH-1:0] sc_hi;
  logic             sc_err;
  logic             long_op;
  logic             is_div;
  logic             div_zero;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             eng_load;
  logic [WIDTH-1:0] eng_hi;
  logic [WIDTH-1:0] eng_lo;
  logic             eng_last;

  logic             op_div;
  logic             neg_q;
  logic             neg_r;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] fix_lo;
  logic [WIDTH-1:0] fix_hi;

  // Undefined codes (including X/Z in simulation) fall through to the default arm.
  always_comb begin
    sc_lo    = '0;
    sc_err   = 1'b0;
    long_op  = 1'b0;
    is_div   = 1'b0;
    div_zero = 1'b0;
    case (ALUS)
      ALU_AND:  sc_lo = A & B;
      ALU_OR:   sc_lo = A | B;
      ALU_ADD:  sc_lo = A + B;
      ALU_SUB:  sc_lo = A - B;
      ALU_SLT:  sc_lo = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      ALU_MULT: long_op = 1'b1;
      ALU_DIV: begin
        if (B == '0) begin
          div_zero = 1'b1;
          sc_lo    = '1;
        end else begin
          long_op = 1'b1;
          is_div  = 1'b1;
        end
      end
      default:  sc_err = 1'b1;
    endcase
  end

  assign sc_hi = div_zero ? A : '0;

  assign a_mag    = A[WIDTH-1] ? -A : A;
  assign b_mag    = B[WIDTH-1] ? -B : B;
  assign eng_load = (state == S_IDLE) && Start && long_op;

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (eng_load),
    .div_mode (is_div),
    .ld_m     (is_div ? b_mag : a_mag),
    .ld_q     (is_div ? a_mag : b_mag),
    .step     (state == S_ITER),
    .nxt_hi   (eng_hi),
    .nxt_lo   (eng_lo),
    .last     (eng_last)
  );

  // Sign fix is applied to the final step's value so the result is registered as Done rises.
  assign prod     = {eng_hi, eng_lo};
  assign prod_fix = neg_q ? -prod : prod;
  assign fix_lo   = op_div ? (neg_q ? -eng_lo : eng_lo) : prod_fix[WIDTH-1:0];
  assign fix_hi   = op_div ? (neg_r ? -eng_hi : eng_hi) : prod_fix[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      Lo      <= '0;
      Hi      <= '0;
      Zero    <= 1'b1;
      DivZero <= 1'b0;
      OpErr   <= 1'b0;
      op_div  <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (Start) begin
            if (long_op) begin
              state  <= S_ITER;
              Busy   <= 1'b1;
              op_div <= is_div;
              neg_q  <= A[WIDTH-1] ^ B[WIDTH-1];
              neg_r  <= A[WIDTH-1];
            end else begin
              Lo      <= sc_lo;
              Hi      <= sc_hi;
              Zero    <= (sc_lo == '0);
              DivZero <= div_zero;
              OpErr   <= sc_err;
              Done    <= 1'b1;
            end
          end
        end
        S_ITER: begin
          if (eng_last) begin
            state   <= S_FINISH;
            Lo      <= fix_lo;
            Hi      <= fix_hi;
            Zero    <= (fix_lo == '0);
            DivZero <= 1'b0;
            OpErr   <= 1'b0;
            Done    <= 1'b1;
          end
        end
        S_FINISH: begin
          state <= S_IDLE;
          Busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
